// File: rtl/pc_stack_ctrl.sv
// Program-counter unit: increment, jump, relative branch and call/return via an internal LIFO.
// Optional macro PC_TRAP_EN redirects stack faults to TRAP_VEC and pulses trap.
module pc_stack_ctrl #(
  parameter int              AW       = 10,
  parameter int              OFS_W    = 8,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RST_VEC  = '0,
  parameter logic [AW-1:0]   TRAP_VEC = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_hold,
  input  logic [2:0]                 op,
  input  logic [AW-1:0]              target,
  input  logic [OFS_W-1:0]           offset,
  output logic [AW-1:0]              addr_ins,
  output logic [$clog2(DEPTH+1)-1:0] stack_level,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err,
  output logic                       trap
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;
  logic          fault;
  logic          push_en;
  logic [AW-1:0] stack_q [DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] br_ofs;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          full;
  logic          empty;

  assign pc_inc = addr_q + AW'(1);
  assign br_ofs = AW'($signed(offset));
  assign wr_idx = IW'(level_q);
  assign rd_idx = IW'(level_q - LW'(1));
  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);

  always_comb begin
    addr_d  = addr_q;
    level_d = level_q;
    err_d   = err_q;
    fault   = 1'b0;
    push_en = 1'b0;
    if (!pc_hold) begin
      case (op)
        OP_JMP: addr_d = target;
        OP_BR:  addr_d = addr_q + br_ofs;
        OP_CALL: begin
          if (full) begin
            fault = 1'b1;
          end else begin
            push_en = 1'b1;
            addr_d  = target;
            level_d = level_q + LW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            fault = 1'b1;
          end else begin
            addr_d  = stack_q[rd_idx];
            level_d = level_q - LW'(1);
          end
        end
        default: addr_d = pc_inc;
      endcase
      // A faulting CALL/RET leaves the stack untouched and only redirects the PC.
      if (fault) begin
        err_d = 1'b1;
`ifdef PC_TRAP_EN
        addr_d = TRAP_VEC;
`else
        addr_d = pc_inc;
`endif
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= RST_VEC;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Stack storage carries no reset; entries above stack_level are never read.
  always_ff @(negedge clk) begin
    if (!rst && push_en) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

`ifdef PC_TRAP_EN
  logic trap_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= fault;
    end
  end

  assign trap = trap_q;
`else
  logic unused_trap_vec;

  assign unused_trap_vec = ^TRAP_VEC;
  assign trap            = 1'b0;
`endif

  assign addr_ins    = addr_q;
  assign stack_level = level_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule
